// File: rtl/spi_pkg.sv
// spi_pkg: register map, frame length and FSM states for the SPI register target
package spi_pkg;
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY = 4;
  localparam int FRAME_BITS = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
endpackage

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: SPI pins plus the control registers they configure
interface spi_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic txn_commit;
  modport master (
    output sclk, copi, ncs,
    input en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, txn_commit
  );
  modport slave (
    input sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, txn_commit
  );
endinterface

// File: rtl/spi_peripheral_sync_ff.sv
// sync_ff: multi-flop synchronizer for an asynchronous input, with a selectable reset value
module sync_ff #(
  parameter int SYNC_STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= {SYNC_STAGES{RST_VAL}};
    else ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
  assign q_o = ff_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: write-only SPI mode-0 target decoding 16-bit frames into five control registers
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR = 4
) (
  input logic clk,
  input logic rst_n,
  spi_peripheral_if.slave bus
);
  logic sclk_s, copi_s, ncs_s, sclk_h_q, ncs_h_q, commit_q;
  logic sclk_rise, ncs_fall, ncs_rise, frame_ok;
  logic [4:0] cnt_q;
  logic [15:0] sr_q;
  logic [4:0][7:0] regs_q;
  state_e state_q;
  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .d_i(bus.sclk), .q_o(sclk_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (.clk(clk), .rst_n(rst_n), .d_i(bus.copi), .q_o(copi_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (.clk(clk), .rst_n(rst_n), .d_i(bus.ncs), .q_o(ncs_s));
  assign sclk_rise = sclk_s & ~sclk_h_q;
  assign ncs_fall = ~ncs_s & ncs_h_q;
  assign ncs_rise = ncs_s & ~ncs_h_q;
  assign frame_ok = (cnt_q == 5'(FRAME_BITS)) && sr_q[15] && (sr_q[14:8] <= 7'(MAX_ADDR));
  // counter saturates at 17 so an overlong frame can never wrap back to a valid length
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sclk_h_q <= 1'b0;
      ncs_h_q <= 1'b1;
      cnt_q <= '0;
      sr_q <= '0;
      regs_q <= '0;
      commit_q <= 1'b0;
    end else begin
      sclk_h_q <= sclk_s;
      ncs_h_q <= ncs_s;
      commit_q <= 1'b0;
      unique case (state_q)
        IDLE: if (ncs_fall) begin
          state_q <= SHIFT;
          cnt_q <= '0;
          sr_q <= '0;
        end
        SHIFT: if (ncs_fall) begin
          cnt_q <= '0;
          sr_q <= '0;
        end else if (ncs_rise) state_q <= COMMIT;
        else if (sclk_rise && !ncs_s) begin
          sr_q <= {sr_q[14:0], copi_s};
          cnt_q <= (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
        end
        COMMIT: begin
          if (frame_ok) begin
            regs_q[sr_q[10:8]] <= sr_q[7:0];
            commit_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.en_reg_out_7_0 = regs_q[ADDR_EN_OUT_LO];
  assign bus.en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign bus.en_reg_pwm_7_0 = regs_q[ADDR_EN_PWM_LO];
  assign bus.en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign bus.pwm_duty_cycle = regs_q[ADDR_PWM_DUTY];
  assign bus.txn_commit = commit_q;
endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
Write-only SPI target that configures the PWM/output-enable datapath in the top-level TT user module. It receives serial transactions from an external controller on ui_in pins, synchronizes them into the clk domain, decodes a 16-bit frame, and updates five 8-bit control registers: output enables, PWM enables and PWM duty cycle. Its register outputs drive the PWM peripheral directly.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk, copi and ncs (minimum 2).
MAX_ADDR, 4, highest valid register address; writes to higher addresses are dropped.

Ports:
clk  input  1  system clock, 10 MHz nominal
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI serial clock (async to clk), mode 0
copi  input  1  SPI controller-out/peripheral-in data (async)
ncs  input  1  SPI chip select, active low (async)
en_reg_out_7_0  output  8  address 0x00, output enable uo_out[7:0]
en_reg_out_15_8  output  8  address 0x01, output enable uio_out[7:0]
en_reg_pwm_7_0  output  8  address 0x02, PWM enable uo_out[7:0]
en_reg_pwm_15_8  output  8  address 0x03, PWM enable uio_out[7:0]
pwm_duty_cycle  output  8  address 0x04, duty cycle (0x00 = 0 %, 0xFF = 100 %)
txn_commit  output  1  one-clk pulse when a valid write updates a register

Behaviour:
- Reset (rst_n low, asynchronous): all five registers 0x00, txn_commit 0, shift register 0, bit counter 0, synchronizers reset to sclk=0, copi=0, ncs=1. FSM to IDLE.
- Synchronizers: SYNC_STAGES flops per input plus one history flop for edge detection on sclk and ncs. Legal timing: sclk high and low each >= 3 clk periods; ncs setup/hold to first/last sclk edge >= 3 clk periods.
- Frame, MSB first, sampled on synchronized sclk rising edge: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- FSM:
  IDLE: wait for synchronized ncs falling edge -> SHIFT; clear bit counter (5 bits, saturating at 17) and shift register.
  SHIFT: on each sclk rising edge shift copi in and increment counter. sclk edges are ignored unless ncs is low. On ncs rising edge -> COMMIT.
  COMMIT (one cycle): if counter == 16 AND R/W == 1 AND address <= MAX_ADDR, write data to the addressed register and pulse txn_commit; otherwise discard silently. Then -> IDLE.
- Latency: register value and txn_commit change on the clk edge after COMMIT is entered, i.e. SYNC_STAGES+2 clk cycles after the raw ncs rising edge.
- Read frames (bit15 = 0): no register change, no commit pulse; copi only, so no read-data path exists.
- Short (<16) or long (>16) frames: discarded; counter saturates so a frame longer than 31 bits cannot alias to 16.
- ncs falling edge while in SHIFT (glitch) restarts the frame: counter and shift register cleared.
- Reset mid-frame: frame lost, registers return to 0x00; the next ncs falling edge starts cleanly.
- Registers hold their value indefinitely between writes; the same address written twice takes the last value.

Decomposition:
- Shared package spi_pkg: register address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_PWM_DUTY=0x04; FRAME_BITS=16; FSM state enum {IDLE, SHIFT, COMMIT}.
- One sub-module: sync_ff (parameterized SYNC_STAGES, async active-low reset, reset value parameter), instantiated three times (ncs reset value 1).

Test Plan:
- Reset: assert rst_n=0 mid-run -> all five registers 0x00 and txn_commit 0 immediately, without waiting for a clk edge.
- Write 0x80F0 then 0x8155 (sclk = clk/10) -> en_reg_out_7_0=0xF0, en_reg_out_15_8=0x55, one txn_commit pulse per frame, others 0x00.
- Write 0x8480 -> pwm_duty_cycle=0x80 exactly SYNC_STAGES+2 clk cycles after the ncs rise; the prior registers are unchanged.
- Read frame 0x02AA and out-of-range write 0x85FF -> no register change, no txn_commit.
- 15-bit frame and 17-bit frame carrying 0x83FF -> en_reg_pwm_15_8 stays 0x00; a following correct 0x83FF frame sets it to 0xFF.
- Assert rst_n low after bit 8 of 0x82CC, release it, then send a full 0x82CC frame -> en_reg_pwm_7_0=0xCC with a single commit pulse.
